ora_cmp_ctrl: RTL

//  Sequential back end of comparison-based ORA #2. Instantiates comp on CUT response A vs golden B,

---
 rtl/ora_cmp_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ora_cmp_ctrl.sv
// Comparison-based output response analyser back end: compares CUT response A against golden B
// over a fixed-length session and reports pass/fail, mismatch count and the first failing pattern.

module comp #(
   parameter int BITS = 2
) (
   input  logic [0:BITS-1] a,
   input  logic [0:BITS-1] b,
   output logic [0:BITS-1] diff,
   output logic            res
);

   assign diff = a ^ b;
   assign res  = |diff;

endmodule

module ora_cmp_ctrl #(
   parameter  int BITS     = 2,
   parameter  int PATTERNS = 16,
   parameter  int CNT_W    = 8,
   localparam int IDX_W    = $clog2(PATTERNS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             valid,
   input  logic [0:BITS-1]  A,
   input  logic [0:BITS-1]  B,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [IDX_W-1:0] first_fail_idx,
   output logic [BITS-1:0]  first_fail_vec
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] idx;
   logic             fail_seen;
   logic [0:BITS-1]  diff;
   logic             res;
   logic             start_session;
   logic             sample;
   logic             last_sample;
   logic [CNT_W-1:0] cnt_next;

   comp #(.BITS(BITS)) u_comp (
      .a    (A),
      .b    (B),
      .diff (diff),
      .res  (res)
   );

   assign start_session = start && (state != RUN);
   assign sample        = valid && (state == RUN);
   assign last_sample   = sample && (idx == IDX_W'(PATTERNS - 1));
   assign cnt_next      = (res && (mismatch_cnt != '1)) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;

   // Status outputs decode the state register only, so nothing reaches them from the inputs.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_sample) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // The final sample of a session is still counted; pass looks at the count including it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
         first_fail_vec <= '0;
         idx            <= '0;
         fail_seen      <= 1'b0;
         pass           <= 1'b0;
      end else if (start_session) begin
         mismatch_cnt   <= '0;
         first_fail_idx <= '0;
         first_fail_vec <= '0;
         idx            <= '0;
         fail_seen      <= 1'b0;
         pass           <= 1'b0;
      end else if (sample) begin
         mismatch_cnt <= cnt_next;
         if (res && !fail_seen) begin
            first_fail_idx <= idx;
            first_fail_vec <= diff;
            fail_seen      <= 1'b1;
         end
         if (last_sample) begin
            pass <= (cnt_next == '0);
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

endmodule
